// File: rtl/mem_mask_rmw.sv
// mem_mask_rmw: masked-write front end for an unmasked 1r1w register-file macro.
// Full-mask writes go straight to port B. Partial-mask writes become a
// read (port A), a lane merge, and a write (port B) over three cycles.
// Optional feature macro: MEM_RMW_BYPASS_EN. When it is defined, a read of
// the RMW address issued in MERGE is served from a bypass register. When it
// is not defined, that read is stalled for one cycle instead.
module mem_mask_rmw #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int GRAN   = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          R0_addr,
  input  logic                       R0_en,
  output logic                       R0_ready,
  output logic [DATA_W-1:0]          R0_data,
  output logic                       R0_valid,
  input  logic [ADDR_W-1:0]          W0_addr,
  input  logic                       W0_en,
  input  logic [DATA_W-1:0]          W0_data,
  input  logic [(DATA_W/GRAN)-1:0]   W0_mask,
  output logic                       W0_ready,
  output logic [ADDR_W-1:0]          AA,
  output logic                       CENA,
  input  logic [DATA_W-1:0]          QA,
  output logic [ADDR_W-1:0]          AB,
  output logic                       CENB,
  output logic [DATA_W-1:0]          DB
);
  localparam int MASK_W = DATA_W / GRAN;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, MERGE = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [MASK_W-1:0]   r_mask;
  logic                r_rvalid;
  logic [DATA_W-1:0]   w_merged;
  logic                w_full, w_zero, w_partial;
  logic                w_wr_acc, w_rd_acc, w_hazard;

  assign w_full    = &W0_mask;
  assign w_zero    = ~|W0_mask;
  assign w_partial = ~w_full & ~w_zero;

  // Lane merge: the latched lane wins where its mask bit is set; otherwise the
  // old word that the macro returned from the RD cycle is kept.
  genvar g;
  generate
    for (g = 0; g < MASK_W; g++) begin : g_lane
      assign w_merged[g*GRAN +: GRAN] = r_mask[g] ? r_data[g*GRAN +: GRAN]
                                                  : QA[g*GRAN +: GRAN];
    end
  endgenerate

`ifdef MEM_RMW_BYPASS_EN
  // The bypass register covers a same-address read in MERGE, so no stall.
  assign w_hazard = 1'b0;
`else
  // The macro would return pre-merge data, so hold the read for one cycle.
  assign w_hazard = (r_state == MERGE) && (R0_addr == r_addr);
`endif

  assign W0_ready = (r_state == IDLE);
  assign R0_ready = ((r_state == IDLE) || (r_state == MERGE)) && !w_hazard;
  // Both accepts are gated by reset so that a mid-cycle reset quiets the
  // macro ports at once.
  assign w_wr_acc = reset_n & W0_en & W0_ready;
  assign w_rd_acc = reset_n & R0_en & R0_ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_wr_acc && w_partial) w_state_nxt = RD;
      RD:      w_state_nxt = MERGE;
      MERGE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Macro port drive. Port A is idle in RD except for the RMW read, and
  // upstream reads are blocked in RD, so the two sources never collide.
  always_comb begin
    CENA = 1'b1;
    AA   = '0;
    CENB = 1'b1;
    AB   = '0;
    DB   = '0;
    if (w_rd_acc) begin
      CENA = 1'b0;
      AA   = R0_addr;
    end
    if (reset_n && r_state == RD) begin
      CENA = 1'b0;
      AA   = r_addr;
    end
    if (w_wr_acc && w_full) begin
      CENB = 1'b0;
      AB   = W0_addr;
      DB   = W0_data;
    end
    if (reset_n && r_state == MERGE) begin
      CENB = 1'b0;
      AB   = r_addr;
      DB   = w_merged;
    end
  end

  // Latch the partial write. Reset discards it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_mask <= '0;
    end else if (w_wr_acc && w_partial) begin
      r_addr <= W0_addr;
      r_data <= W0_data;
      r_mask <= W0_mask;
    end
  end

  // Read valid trails acceptance by the macro's one-cycle latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rvalid <= 1'b0;
    else          r_rvalid <= w_rd_acc;
  end

  assign R0_valid = r_rvalid;

`ifdef MEM_RMW_BYPASS_EN
  logic              r_byp_hit;
  logic [DATA_W-1:0] r_byp_data;

  // Capture the merged word when a same-address read lands in MERGE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_byp_hit  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp_hit  <= w_rd_acc && (r_state == MERGE) && (R0_addr == r_addr);
      r_byp_data <= w_merged;
    end
  end

  assign R0_data = !r_rvalid ? '0 : (r_byp_hit ? r_byp_data : QA);
`else
  assign R0_data = r_rvalid ? QA : '0;
`endif

endmodule
